alu_addsub_pipe: RTL and testbench
==================================

Name: alu_addsub_pipe

Overview:
- Two-stage pipelined 32-bit adder/subtractor in the execute path.
- Directly upstream of slt_block. Produces the result plus NEG, OVF, ZERO and CARRY flags, and forwards SltType, signInput1 and signInput2 so slt_block can be driven straight from its outputs.
- Splits the carry chain at a half-word boundary: low half in stage 1, high half in stage 2, for timing.
- Provides valid/stall/flush control so the hazard unit can freeze or squash in-flight ops.

Parameters:
- WIDTH, 32: datapath width.
- LO_WIDTH, 16: bits summed in stage 1. The remaining WIDTH-LO_WIDTH bits are summed in stage 2.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  A/B/Sub/SltTypeIn hold a valid op this cycle
- stall  input  1  freeze both stages
- flush  input  1  squash all in-flight ops
- A  input  WIDTH  operand 1
- B  input  WIDTH  operand 2
- Sub  input  1  1 = A-B, 0 = A+B
- SltTypeIn  input  1  0 = slt/slti, 1 = sltu/sltiu; passed through
- in_ready  output  1  equals ~stall (combinational)
- out_valid  output  1  stage-2 outputs hold a valid result
- Sum  output  WIDTH  A+B or A-B, modulo 2^WIDTH
- NEG  output  1  Sum[WIDTH-1]
- OVF  output  1  signed overflow
- ZERO  output  1  Sum == 0
- CARRY  output  1  carry out of the MSB; for Sub, 1 = no borrow
- SltType  output  1  registered SltTypeIn
- signInput1  output  1  registered A[WIDTH-1]
- signInput2  output  1  registered B[WIDTH-1], original B, not inverted

Behaviour:
- Operand prep: Bx = Sub ? ~B : B; carry-in = Sub.
- Stage 1 (S1) registers:
  - lo = A[LO-1:0] + Bx[LO-1:0] + Sub, keeping the carry out c_lo.
  - A_hi and Bx_hi.
  - A MSB, B MSB, Bx MSB.
  - Sub, SltTypeIn.
  - v1.
- Stage 2 (S2) computes:
  - hi = A_hi + Bx_hi + c_lo.
  - Sum = {hi, lo}; CARRY = carry out of hi.
  - OVF = (A_msb == Bx_msb) && (Sum_msb != A_msb); NEG = Sum_msb; ZERO = ~|Sum.
  - All outputs and out_valid are registered.
- Latency: exactly 2 cycles from an accepted input to out_valid with the matching result. Throughput is 1 op/cycle.
- Accept rule: an op enters S1 on a clock edge where in_valid=1, stall=0, flush=0.
- Stall=1 (flush=0): S1, S2, all outputs and out_valid hold their values. Inputs are ignored.
- Flush=1: v1 and out_valid go to 0 at that edge. Flush overrides stall and in_valid, so the op presented that cycle is dropped.
- Bubbles: when stall=0 and v1=0, out_valid goes to 0 next edge. Sum/flag outputs update only when a valid op moves into S2; otherwise they hold their last value.
- Reset (synchronous, highest priority):
  - v1 and out_valid cleared.
  - Sum, NEG, OVF, ZERO, CARRY, SltType, signInput1, signInput2 and all S1 data registers cleared to 0.
  - Reset mid-operation discards in-flight ops with no partial output.
- Arithmetic wraps modulo 2^WIDTH with no saturation. Flags are defined for every op, including Add.
- Downstream contract: slt_block computes NEG^OVF for signed compares and uses signInput1/signInput2/NEG for unsigned compares. No extra conditioning of these outputs is needed.

Decomposition:
- Shared CPU package holds:
  - ALU_WIDTH = 32 and ALU_LO_WIDTH = 16.
  - SLT_SIGNED = 0 and SLT_UNSIGNED = 1 encodings.
  - A flag struct/typedef {NEG, OVF, ZERO, CARRY}.
- One natural sub-module: addsub_slice, a parameterised-width adder taking cin and returning {cout, sum}. It is instantiated once per stage.

Test Plan:
1. Add A=0x0000FFFF, B=0x00000001, in_valid=1 → 2 cycles later: out_valid=1, Sum=0x00010000, NEG=0, OVF=0, ZERO=0, CARRY=0. This checks the carry crossing the half-word split.
2. Sub A=0x80000000, B=0x00000001, SltTypeIn=0 → Sum=0x7FFFFFFF, NEG=0, OVF=1, CARRY=1, signInput1=1, signInput2=0. The slt_block result is 1.
3. Sub A=0x00000005, B=0x00000005 → Sum=0, ZERO=1, CARRY=1, NEG=0, OVF=0. Sub A=0, B=1 → Sum=0xFFFFFFFF, CARRY=0, NEG=1.
4. Issue ops X, Y, Z on consecutive cycles with stall=1 for 2 cycles right after Y is accepted → out_valid and Sum frozen during the stall. After release, X, Y, Z results appear in order with no loss or duplication.
5. Two ops in flight, then flush=1 together with stall=1 and in_valid=1 → next cycle out_valid=0 and the presented op is dropped. The next accepted op appears exactly 2 cycles after acceptance.
6. Reset asserted while two ops are in flight → next edge: out_valid=0 and all outputs 0. After reset release, a new Add 1+2 gives Sum=3 after 2 cycles.

Source files
------------

// File: rtl/alu_addsub_pipe_pkg.sv
// Shared execute-path definitions for the pipelined adder/subtractor and the
// slt_block it feeds.
package alu_addsub_pipe_pkg;

  localparam int ALU_WIDTH    = 32;
  localparam int ALU_LO_WIDTH = 16;

  // SltType encodings, consumed by slt_block
  localparam logic SLT_SIGNED   = 1'b0;
  localparam logic SLT_UNSIGNED = 1'b1;

  typedef struct packed {
    logic neg;
    logic ovf;
    logic zero;
    logic carry;
  } flags_t;

endpackage

// File: rtl/alu_addsub_pipe_addsub_slice.sv
// Parameterised-width ripple adder slice: res = {cout, a + b + cin}.
module addsub_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W:0]   res
);

  assign res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/alu_addsub_pipe.sv
// Two-stage 32-bit add/sub with NEG/OVF/ZERO/CARRY flags and slt pass-through.
// The carry chain is split: low half summed in S1, high half in S2.
module alu_addsub_pipe
  import alu_addsub_pipe_pkg::*;
#(
  parameter int WIDTH    = ALU_WIDTH,
  parameter int LO_WIDTH = ALU_LO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  input  logic             SltTypeIn,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             NEG,
  output logic             OVF,
  output logic             ZERO,
  output logic             CARRY,
  output logic             SltType,
  output logic             signInput1,
  output logic             signInput2
);

  localparam int HI_WIDTH = WIDTH - LO_WIDTH;

  // Operand prep: two's-complement subtract as A + ~B + 1
  logic [WIDTH-1:0]    bx;
  logic [LO_WIDTH:0]   lo_res;
  logic [HI_WIDTH:0]   hi_res;

  assign bx       = Sub ? ~B : B;
  assign in_ready = ~stall;

  addsub_slice #(.W(LO_WIDTH)) u_lo (
    .a   (A[LO_WIDTH-1:0]),
    .b   (bx[LO_WIDTH-1:0]),
    .cin (Sub),
    .res (lo_res)
  );

  // Stage 1 registers
  logic [LO_WIDTH-1:0] lo_reg;
  logic                c_lo_reg;
  logic [HI_WIDTH-1:0] a_hi_reg;
  logic [HI_WIDTH-1:0] bx_hi_reg;
  logic                a_msb_reg;
  logic                b_msb_reg;
  logic                bx_msb_reg;
  logic                slt_type1_reg;
  logic                v1_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      lo_reg        <= '0;
      c_lo_reg      <= 1'b0;
      a_hi_reg      <= '0;
      bx_hi_reg     <= '0;
      a_msb_reg     <= 1'b0;
      b_msb_reg     <= 1'b0;
      bx_msb_reg    <= 1'b0;
      slt_type1_reg <= 1'b0;
      v1_reg        <= 1'b0;
    end else if (flush) begin
      v1_reg <= 1'b0;
    end else if (!stall) begin
      v1_reg <= in_valid;
      if (in_valid) begin
        lo_reg        <= lo_res[LO_WIDTH-1:0];
        c_lo_reg      <= lo_res[LO_WIDTH];
        a_hi_reg      <= A[WIDTH-1:LO_WIDTH];
        bx_hi_reg     <= bx[WIDTH-1:LO_WIDTH];
        a_msb_reg     <= A[WIDTH-1];
        b_msb_reg     <= B[WIDTH-1];
        bx_msb_reg    <= bx[WIDTH-1];
        slt_type1_reg <= SltTypeIn;
      end
    end
  end

  addsub_slice #(.W(HI_WIDTH)) u_hi (
    .a   (a_hi_reg),
    .b   (bx_hi_reg),
    .cin (c_lo_reg),
    .res (hi_res)
  );

  logic [WIDTH-1:0] sum_next;
  flags_t           flags_next;

  always_comb begin
    sum_next         = {hi_res[HI_WIDTH-1:0], lo_reg};
    flags_next.neg   = sum_next[WIDTH-1];
    flags_next.ovf   = (a_msb_reg == bx_msb_reg) && (sum_next[WIDTH-1] != a_msb_reg);
    flags_next.zero  = ~|sum_next;
    flags_next.carry = hi_res[HI_WIDTH];
  end

  // Stage 2 / output registers; data only moves on a valid op so bubbles hold
  logic [WIDTH-1:0] sum_reg;
  flags_t           flags_reg;
  logic             slt_type_reg;
  logic             sign1_reg;
  logic             sign2_reg;
  logic             out_valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_reg       <= '0;
      flags_reg     <= '0;
      slt_type_reg  <= 1'b0;
      sign1_reg     <= 1'b0;
      sign2_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (!stall) begin
      out_valid_reg <= v1_reg;
      if (v1_reg) begin
        sum_reg      <= sum_next;
        flags_reg    <= flags_next;
        slt_type_reg <= slt_type1_reg;
        sign1_reg    <= a_msb_reg;
        sign2_reg    <= b_msb_reg;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign Sum        = sum_reg;
  assign NEG        = flags_reg.neg;
  assign OVF        = flags_reg.ovf;
  assign ZERO       = flags_reg.zero;
  assign CARRY      = flags_reg.carry;
  assign SltType    = slt_type_reg;
  assign signInput1 = sign1_reg;
  assign signInput2 = sign2_reg;

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Directed-vector bench for alu_addsub_pipe: arithmetic, flags, latency,
// stall, flush and reset behaviour.
module tb_alu_addsub_pipe;
  import alu_addsub_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush, Sub, SltTypeIn;
  logic [31:0] A, B;
  logic        in_ready, out_valid, NEG, OVF, ZERO, CARRY, SltType, signInput1, signInput2;
  logic [31:0] Sum;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_addsub_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .stall      (stall),
    .flush      (flush),
    .A          (A),
    .B          (B),
    .Sub        (Sub),
    .SltTypeIn  (SltTypeIn),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .Sum        (Sum),
    .NEG        (NEG),
    .OVF        (OVF),
    .ZERO       (ZERO),
    .CARRY      (CARRY),
    .SltType    (SltType),
    .signInput1 (signInput1),
    .signInput2 (signInput2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Inputs change 1 time unit after the edge and outputs are sampled there too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic slt);
    in_valid  = v;
    A         = a;
    B         = b;
    Sub       = sub;
    SltTypeIn = slt;
  endtask

  // flags packed as {NEG, OVF, ZERO, CARRY}
  task automatic check_res(input string tag, input logic [31:0] exp_sum, input logic [3:0] exp_flags);
    check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, ".sum"}, Sum, exp_sum);
    check({tag, ".flags"}, {28'b0, NEG, OVF, ZERO, CARRY}, {28'b0, exp_flags});
  endtask

  // Single op through an empty pipe: result must appear exactly two edges later
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic slt);
    drive(1'b1, a, b, sub, slt);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check({tag, ".lat1"}, {31'b0, out_valid}, 32'd0);
    step();
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) step();
    check("rst.valid", {31'b0, out_valid}, 32'd0);
    check("rst.sum", Sum, 32'h0);
    check("rst.flags", {28'b0, NEG, OVF, ZERO, CARRY}, 32'h0);
    check("rst.in_ready", {31'b0, in_ready}, 32'd1);
    reset = 1'b0;
    step();

    // carry crossing the half-word split
    run_op("add_split", 32'h0000FFFF, 32'h00000001, 1'b0, SLT_SIGNED);
    check_res("add_split", 32'h00010000, 4'b0000);

    // signed overflow on subtract
    run_op("sub_ovf", 32'h80000000, 32'h00000001, 1'b1, SLT_SIGNED);
    check_res("sub_ovf", 32'h7FFFFFFF, 4'b0101);
    check("sub_ovf.s1", {31'b0, signInput1}, 32'd1);
    check("sub_ovf.s2", {31'b0, signInput2}, 32'd0);
    check("sub_ovf.slt", {31'b0, SltType}, 32'd0);
    check("sub_ovf.lt", {31'b0, NEG ^ OVF}, 32'd1);

    run_op("sub_eq", 32'h5, 32'h5, 1'b1, SLT_UNSIGNED);
    check_res("sub_eq", 32'h0, 4'b0011);
    check("sub_eq.slt", {31'b0, SltType}, 32'd1);

    run_op("sub_borrow", 32'h0, 32'h1, 1'b1, SLT_UNSIGNED);
    check_res("sub_borrow", 32'hFFFFFFFF, 4'b1000);

    // signInput2 must be the original B sign, not the inverted one
    run_op("sub_negb", 32'h1, 32'h80000000, 1'b1, SLT_SIGNED);
    check_res("sub_negb", 32'h80000001, 4'b1100);
    check("sub_negb.s1", {31'b0, signInput1}, 32'd0);
    check("sub_negb.s2", {31'b0, signInput2}, 32'd1);

    run_op("add_ovf", 32'h7FFFFFFF, 32'h1, 1'b0, SLT_SIGNED);
    check_res("add_ovf", 32'h80000000, 4'b1100);

    run_op("add_wrap", 32'hFFFFFFFF, 32'h1, 1'b0, SLT_SIGNED);
    check_res("add_wrap", 32'h0, 4'b0011);

    // X, Y, Z back-to-back with a 2-cycle stall right after Y is accepted
    drive(1'b1, 32'd10, 32'd20, 1'b0, SLT_SIGNED);   // X = 30
    step();
    drive(1'b1, 32'd100, 32'd1, 1'b1, SLT_SIGNED);   // Y = 99
    step();
    check_res("stall.x", 32'd30, 4'b0000);
    drive(1'b1, 32'd7, 32'd8, 1'b0, SLT_SIGNED);     // Z = 15
    stall = 1'b1;
    #1;
    check("stall.in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check_res($sformatf("stall.hold%0d", i), 32'd30, 4'b0000);
    end
    stall = 1'b0;
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_res("stall.y", 32'd99, 4'b0001);
    step();
    check_res("stall.z", 32'd15, 4'b0000);
    step();
    check("stall.drain", {31'b0, out_valid}, 32'd0);
    check("stall.sum_hold", Sum, 32'd15);

    // flush with stall and in_valid: both in-flight ops and the presented op die
    drive(1'b1, 32'd40, 32'd2, 1'b0, SLT_SIGNED);    // P = 42
    step();
    drive(1'b1, 32'd50, 32'd3, 1'b0, SLT_SIGNED);    // Q = 53
    step();
    check_res("flush.p", 32'd42, 4'b0000);
    drive(1'b1, 32'd60, 32'd4, 1'b0, SLT_SIGNED);    // R = 64, dropped
    flush = 1'b1;
    stall = 1'b1;
    step();
    flush = 1'b0;
    stall = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("flush.valid0", {31'b0, out_valid}, 32'd0);
    step();
    check("flush.valid1", {31'b0, out_valid}, 32'd0);
    check("flush.sum_hold", Sum, 32'd42);
    run_op("flush.next", 32'd9, 32'd4, 1'b1, SLT_SIGNED);
    check_res("flush.next", 32'd5, 4'b0001);

    // reset with two ops in flight
    drive(1'b1, 32'h80000000, 32'h80000000, 1'b1, SLT_UNSIGNED);
    step();
    drive(1'b1, 32'hFFFF0000, 32'h0000FFFF, 1'b0, SLT_UNSIGNED);
    step();
    check("rst2.pre_valid", {31'b0, out_valid}, 32'd1);
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    check("rst2.valid", {31'b0, out_valid}, 32'd0);
    check("rst2.sum", Sum, 32'h0);
    check("rst2.flags", {28'b0, NEG, OVF, ZERO, CARRY}, 32'h0);
    check("rst2.side", {29'b0, SltType, signInput1, signInput2}, 32'h0);
    reset = 1'b0;
    step();
    check("rst2.no_partial", {31'b0, out_valid}, 32'd0);
    run_op("rst2.add", 32'd1, 32'd2, 1'b0, SLT_SIGNED);
    check_res("rst2.add", 32'd3, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
